medidor_faixa_uc: RTL and testbench

Moore control unit that sequences the range-meter datapath: periodic HC-SR04 measurement, latching, 4-character serial report "XYZ#", and hit detection.
- Drives the datapath's zera/zera_time/zera_char/conta_time/mensurar/partida_tx/conta_prox_char controls.
- Consumes its status flags: fim_time, pronto_medida, pronto_tx, is_ultimo_char, acertou.
- Sits beside the datapath inside the game/meter top level, one instance per datapath.

---
 rtl/medidor_faixa_uc.sv | 177 +++++++++++++++++
 tb/tb_medidor_faixa_uc.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/medidor_faixa_uc.sv
// Moore control unit for the range meter: measure, latch, send "XYZ#", detect hit.
// Optional echo watchdog enabled by defining MEDIDOR_UC_TIMEOUT_EN.
module medidor_faixa_uc #(
  parameter int TIMEOUT_CYCLES = 2_500_000,
  parameter int TIMEOUT_W      = 22
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ligar,
  input  logic       fim_time,
  input  logic       pronto_medida,
  input  logic       pronto_tx,
  input  logic       is_ultimo_char,
  input  logic       acertou,
  output logic       zera,
  output logic       zera_time,
  output logic       zera_char,
  output logic       conta_time,
  output logic       mensurar,
  output logic       partida_tx,
  output logic       conta_prox_char,
  output logic       pronto,
  output logic       db_timeout,
  output logic [3:0] db_estado
);

  typedef enum logic [3:0] {
    inicial          = 4'd0,
    preparacao       = 4'd1,
    espera_intervalo = 4'd2,
    medir            = 4'd3,
    espera_medida    = 4'd4,
    registra         = 4'd5,
    transmite        = 4'd6,
    espera_tx        = 4'd7,
    prox_char        = 4'd8,
    fim_ciclo        = 4'd9,
    acerto           = 4'd10,
    timeout          = 4'd11
  } estado_t;

  estado_t estado, prox;

  if ((64'd1 << TIMEOUT_W) <= 64'(TIMEOUT_CYCLES)) begin : g_bad_w
    $error("TIMEOUT_W too narrow for TIMEOUT_CYCLES");
  end

`ifdef MEDIDOR_UC_TIMEOUT_EN
  logic [TIMEOUT_W-1:0] wd_cnt;
  logic                 wd_fim;
  logic                 to_flag;

  assign wd_fim = (wd_cnt == TIMEOUT_W'(TIMEOUT_CYCLES - 1));

  // Counter restarts in medir so it reads 0 on the first cycle of espera_medida
  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      wd_cnt <= '0;
    else if (estado == medir)
      wd_cnt <= '0;
    else if (estado == espera_medida)
      wd_cnt <= wd_cnt + 1'b1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      to_flag <= 1'b0;
    else if (prox == timeout)
      to_flag <= 1'b1;
    else if (prox == preparacao)
      to_flag <= 1'b0;
  end

  assign db_timeout = to_flag;
`else
  assign db_timeout = 1'b0;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      estado <= inicial;
    else
      estado <= prox;
  end

  always_comb begin
    prox = inicial;
    unique case (estado)
      inicial:
        prox = ligar ? preparacao : inicial;
      preparacao:
        prox = espera_intervalo;
      espera_intervalo:
        if (!ligar)
          prox = inicial;
        else if (fim_time)
          prox = medir;
        else
          prox = espera_intervalo;
      medir:
        prox = espera_medida;
      espera_medida:
        if (pronto_medida)
          prox = registra;
`ifdef MEDIDOR_UC_TIMEOUT_EN
        else if (wd_fim)
          prox = timeout;
`endif
        else
          prox = espera_medida;
      registra:
        prox = transmite;
      transmite:
        prox = espera_tx;
      espera_tx:
        if (pronto_tx)
          prox = is_ultimo_char ? fim_ciclo : prox_char;
        else
          prox = espera_tx;
      prox_char:
        prox = transmite;
      fim_ciclo:
        if (acertou)
          prox = acerto;
        else if (ligar)
          prox = espera_intervalo;
        else
          prox = inicial;
      acerto:
        prox = ligar ? acerto : inicial;
`ifdef MEDIDOR_UC_TIMEOUT_EN
      timeout:
        prox = ligar ? espera_intervalo : inicial;
`endif
      default:
        prox = inicial;
    endcase
  end

  always_comb begin
    zera            = 1'b0;
    zera_time       = 1'b0;
    zera_char       = 1'b0;
    conta_time      = 1'b0;
    mensurar        = 1'b0;
    partida_tx      = 1'b0;
    conta_prox_char = 1'b0;
    pronto          = 1'b0;
    unique case (estado)
      preparacao: begin
        zera      = 1'b1;
        zera_time = 1'b1;
        zera_char = 1'b1;
      end
      espera_intervalo: conta_time      = 1'b1;
      medir:            mensurar        = 1'b1;
      transmite:        partida_tx      = 1'b1;
      prox_char:        conta_prox_char = 1'b1;
      fim_ciclo: begin
        zera_char = 1'b1;
        zera_time = 1'b1;
      end
      acerto:           pronto          = 1'b1;
`ifdef MEDIDOR_UC_TIMEOUT_EN
      timeout: begin
        zera      = 1'b1;
        zera_time = 1'b1;
        zera_char = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  assign db_estado = estado;

endmodule

// File: tb/tb_medidor_faixa_uc.sv
// Directed bench for medidor_faixa_uc; define MEDIDOR_UC_TIMEOUT_EN to also
// exercise the watchdog (DUT built with TIMEOUT_CYCLES=50).
module tb_medidor_faixa_uc;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       ligar = 1'b0;
  logic       fim_time = 1'b0;
  logic       pronto_medida = 1'b0;
  logic       pronto_tx = 1'b0;
  logic       is_ultimo_char = 1'b0;
  logic       acertou = 1'b0;
  logic       zera, zera_time, zera_char, conta_time;
  logic       mensurar, partida_tx, conta_prox_char;
  logic       pronto, db_timeout;
  logic [3:0] db_estado;

  int n_cmp = 0;
  int n_err = 0;
  int n_mens = 0;
  int n_part = 0;
  int n_prox = 0;

  medidor_faixa_uc #(
    .TIMEOUT_CYCLES(50),
    .TIMEOUT_W(6)
  ) dut (
    .clock(clock),
    .reset(reset),
    .ligar(ligar),
    .fim_time(fim_time),
    .pronto_medida(pronto_medida),
    .pronto_tx(pronto_tx),
    .is_ultimo_char(is_ultimo_char),
    .acertou(acertou),
    .zera(zera),
    .zera_time(zera_time),
    .zera_char(zera_char),
    .conta_time(conta_time),
    .mensurar(mensurar),
    .partida_tx(partida_tx),
    .conta_prox_char(conta_prox_char),
    .pronto(pronto),
    .db_timeout(db_timeout),
    .db_estado(db_estado)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (mensurar) n_mens++;
    if (partida_tx) n_part++;
    if (conta_prox_char) n_prox++;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic clr_counts();
    n_mens = 0;
    n_part = 0;
    n_prox = 0;
  endtask

  // From espera_intervalo: one full measure + 4-char report, ends in fim_ciclo
  task automatic report(input int drop_at);
    tick(10);
    chk("wait_interval", db_estado, 2);
    chk("conta_time", conta_time, 1);
    fim_time = 1'b1;
    tick;
    fim_time = 1'b0;
    chk("medir", db_estado, 3);
    chk("mensurar", mensurar, 1);
    tick;
    chk("espera_medida", db_estado, 4);
    tick(19);
    chk("still_medida", db_estado, 4);
    pronto_medida = 1'b1;
    tick;
    pronto_medida = 1'b0;
    chk("registra", db_estado, 5);
    tick;
    for (int c = 0; c < 4; c++) begin
      chk("transmite", db_estado, 6);
      chk("partida_tx", partida_tx, 1);
      tick;
      chk("espera_tx", db_estado, 7);
      if (c == drop_at) ligar = 1'b0;
      tick(4);
      chk("hold_tx", db_estado, 7);
      is_ultimo_char = (c == 3);
      pronto_tx = 1'b1;
      tick;
      pronto_tx = 1'b0;
      is_ultimo_char = 1'b0;
      if (c < 3) begin
        chk("prox_char", db_estado, 8);
        chk("conta_prox", conta_prox_char, 1);
        tick;
      end else begin
        chk("fim_ciclo", db_estado, 9);
        chk("fim_zera", {zera, zera_time, zera_char}, 3'b011);
      end
    end
  endtask

  initial begin
    // 1: reset with ligar high, then start-up sequence
    ligar = 1'b1;
    tick(2);
    chk("rst_outs", {zera, zera_time, zera_char, conta_time, mensurar,
        partida_tx, conta_prox_char, pronto, db_timeout, db_estado}, 13'h0);
    reset = 1'b0;
    tick;
    chk("preparacao", db_estado, 1);
    chk("prep_zeros", {zera, zera_time, zera_char, conta_time}, 4'b1110);
    chk("prep_to", db_timeout, 0);
    tick;
    chk("to_interval", db_estado, 2);
    chk("zeros_off", {zera, zera_time, zera_char}, 3'b000);

    // 2: plain cycle returns to espera_intervalo
    clr_counts();
    report(-1);
    tick;
    chk("cycle_back", db_estado, 2);
    chk("n_mens", n_mens, 1);
    chk("n_part", n_part, 4);
    chk("n_prox", n_prox, 3);

    // 3: hit -> acerto, hold while ligar, leave on ligar=0
    report(-1);
    acertou = 1'b1;
    tick;
    acertou = 1'b0;
    chk("acerto", db_estado, 10);
    chk("pronto", pronto, 1);
    tick(100);
    chk("acerto_hold", db_estado, 10);
    chk("pronto_hold", pronto, 1);
    ligar = 1'b0;
    tick;
    chk("acerto_exit", db_estado, 0);
    chk("pronto_off", pronto, 0);

    // 4: ligar drop during char 1 still finishes the report
    ligar = 1'b1;
    tick(2);
    chk("restart", db_estado, 2);
    clr_counts();
    report(1);
    chk("drop_ligar", ligar, 0);
    tick;
    chk("drop_inicial", db_estado, 0);
    chk("drop_n_part", n_part, 4);
    chk("drop_n_prox", n_prox, 3);

    // 6: stray pulses ignored, async reset in espera_tx
    ligar = 1'b1;
    tick(2);
    pronto_tx = 1'b1;
    pronto_medida = 1'b1;
    tick;
    pronto_tx = 1'b0;
    pronto_medida = 1'b0;
    chk("stray_ignored", db_estado, 2);
    fim_time = 1'b1;
    tick(2);
    fim_time = 1'b0;
    chk("stray_medida", db_estado, 4);

`ifdef MEDIDOR_UC_TIMEOUT_EN
    // 5: watchdog expiry, then pronto_medida on the expiry cycle wins
    tick(49);
    chk("wd_49", db_estado, 4);
    tick;
    chk("timeout", db_estado, 11);
    chk("to_zera", {zera, zera_time, zera_char}, 3'b111);
    chk("to_flag", db_timeout, 1);
    tick;
    chk("to_back", db_estado, 2);
    chk("to_zera_off", zera, 0);
    chk("to_sticky", db_timeout, 1);
    fim_time = 1'b1;
    tick(2);
    fim_time = 1'b0;
    chk("wd2_medida", db_estado, 4);
    tick(49);
    pronto_medida = 1'b1;
    tick;
    pronto_medida = 1'b0;
    chk("wd2_registra", db_estado, 5);
`else
    tick(60);
    chk("no_wd", db_estado, 4);
    chk("no_wd_flag", db_timeout, 0);
    pronto_medida = 1'b1;
    tick;
    pronto_medida = 1'b0;
    chk("late_registra", db_estado, 5);
`endif
    tick(2);
    chk("pre_rst_tx", db_estado, 7);
    reset = 1'b1;
    #1;
    chk("async_rst", db_estado, 0);
    chk("rst_tx_outs", {partida_tx, conta_prox_char}, 2'b00);
    tick(2);
    chk("rst_hold", db_estado, 0);
    reset = 1'b0;
    tick;
    chk("rst_prep", db_estado, 1);
    chk("rst_prep_to", db_timeout, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
